// File: rtl/mem_responder.sv
// Bus responder for the 6502 core: decodes a captured request against RAM, one I/O byte and
// the reset vector bytes, and completes it after a fixed number of wait cycles with a rdy pulse.
module mem_responder #(
   parameter int unsigned RAM_AW      = 11,
   parameter int unsigned WAIT_STATES = 1,
   parameter logic [15:0] IO_ADDR     = 16'hF000,
   parameter logic [15:0] RESET_VEC   = 16'h0200,
   parameter logic [7:0]  FILL_BYTE   = 8'hEA
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic [15:0] addr,
   input  logic        mem_rw,
   input  logic [7:0]  wdata,
   output logic [7:0]  rdata,
   output logic        rdy,
   output logic        bus_err,
   input  logic [7:0]  io_in,
   output logic [7:0]  io_out,
   output logic        io_stb
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   localparam logic [3:0]  WS_L    = 4'(WAIT_STATES);
   localparam logic [16:0] RAM_TOP = 17'(2 ** RAM_AW);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] addr_q, addr_d;
   logic        rw_q, rw_d;
   logic [7:0]  wdata_q, wdata_d;
   logic [7:0]  rdata_q;
   logic [7:0]  io_out_q;
   logic [7:0]  mem_q [2 ** RAM_AW];

   logic        io_hit, vec_lo, vec_hi, ram_hit, unmapped;
   logic        resp;
   logic [7:0]  rd_byte;

   // Decode priority: I/O byte, then vector bytes, then RAM; no aliasing above the RAM range
   assign io_hit   = (addr_q == IO_ADDR);
   assign vec_lo   = !io_hit && (addr_q == 16'hFFFC);
   assign vec_hi   = !io_hit && (addr_q == 16'hFFFD);
   assign ram_hit  = !io_hit && ({1'b0, addr_q} < RAM_TOP);
   assign unmapped = !(io_hit || vec_lo || vec_hi || ram_hit);

   // A reset sampled in the response cycle abandons the transaction, so it gates every effect
   assign resp = (state_q == S_RESP) && rst_n;

   always_comb begin
      rd_byte = FILL_BYTE;
      if (io_hit)       rd_byte = io_in;
      else if (vec_lo)  rd_byte = RESET_VEC[7:0];
      else if (vec_hi)  rd_byte = RESET_VEC[15:8];
      else if (ram_hit) rd_byte = mem_q[addr_q[RAM_AW-1:0]];
   end

   assign rdy     = resp;
   assign bus_err = resp && unmapped;
   assign io_stb  = resp && !rw_q && io_hit;
   assign rdata   = (resp && rw_q) ? rd_byte : rdata_q;
   assign io_out  = io_out_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      rw_d    = rw_q;
      wdata_d = wdata_q;
      case (state_q)
         S_IDLE: begin
            cnt_d = 4'd0;
            if (req) begin
               addr_d  = addr;
               rw_d    = mem_rw;
               wdata_d = wdata;
               if (WS_L == 4'd0) begin
                  state_d = S_RESP;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = 4'd1;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == WS_L) begin
               state_d = S_RESP;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= 4'd0;
         rdata_q  <= 8'h00;
         io_out_q <= 8'h00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (resp && rw_q)
            rdata_q <= rd_byte;
         if (resp && !rw_q && io_hit)
            io_out_q <= wdata_q;
      end
   end

   // Captured request fields only matter once the FSM leaves IDLE, so they carry no reset
   always_ff @(posedge clk) begin
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
   end

   always_ff @(posedge clk) begin
      if (resp && !rw_q && ram_hit)
         mem_q[addr_q[RAM_AW-1:0]] <= wdata_q;
   end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a driver issues requests and queues expected responses
// from a simple memory-map model; a monitor compares whenever rdy is presented.
module tb_mem_responder;

   localparam int WS = 1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req = 1'b0;
   logic [15:0] addr = 16'h0000;
   logic        mem_rw = 1'b1;
   logic [7:0]  wdata = 8'h00;
   logic [7:0]  io_in = 8'h00;
   logic [7:0]  rdata;
   logic        rdy;
   logic        bus_err;
   logic [7:0]  io_out;
   logic        io_stb;

   always #5 clk = ~clk;

   mem_responder #(
      .RAM_AW(11), .WAIT_STATES(WS), .IO_ADDR(16'hF000),
      .RESET_VEC(16'h0200), .FILL_BYTE(8'hEA)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .addr(addr), .mem_rw(mem_rw),
      .wdata(wdata), .rdata(rdata), .rdy(rdy), .bus_err(bus_err),
      .io_in(io_in), .io_out(io_out), .io_stb(io_stb)
   );

   typedef struct {
      logic       rd;
      logic [7:0] rdata;
      logic       berr;
      logic       stb;
      logic [7:0] io_out;
   } exp_t;

   exp_t        sb_q[$];
   int          checks = 0;
   int          errors = 0;
   int unsigned cyc = 0;
   int unsigned last_rdy_cyc = 0;
   int unsigned rdy_gap = 0;

   // Reference memory map
   logic [7:0]  mem_m [0:2047];
   logic [7:0]  m_io = 8'h00;
   logic [7:0]  m_last = 8'h00;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic exp_t model(input logic [15:0] a, input logic rw,
                                  input logic [7:0] wd, input logic [7:0] iov);
      exp_t       e;
      logic [7:0] v;
      e.berr = 1'b0;
      e.stb  = 1'b0;
      v      = 8'hEA;
      if (a == 16'hF000) begin
         if (rw) v = iov;
         else begin
            m_io  = wd;
            e.stb = 1'b1;
         end
      end else if (a == 16'hFFFC) begin
         v = 8'h00;
      end else if (a == 16'hFFFD) begin
         v = 8'h02;
      end else if (a < 16'h0800) begin
         if (rw) v = mem_m[a[10:0]];
         else    mem_m[a[10:0]] = wd;
      end else begin
         e.berr = 1'b1;
      end
      if (rw) m_last = v;
      e.rd     = rw;
      e.rdata  = m_last;
      e.io_out = m_io;
      return e;
   endfunction

   // mode 1: scramble address/direction/data in WAIT; mode 2: drop req in WAIT
   task automatic issue(input logic [15:0] a, input logic rw, input logic [7:0] wd,
                        input logic [7:0] iov, input int mode, input bit hold);
      int n;
      bit seen;
      io_in  = iov;
      addr   = a;
      mem_rw = rw;
      wdata  = wd;
      req    = 1'b1;
      sb_q.push_back(model(a, rw, wd, iov));
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 20) begin
         @(posedge clk); #1;
         n++;
         if (rdy) seen = 1'b1;
         else if (n == 1 && mode == 1) begin
            addr   = ~a;
            mem_rw = ~rw;
            wdata  = ~wd;
         end else if (n == 1 && mode == 2) begin
            req = 1'b0;
         end
      end
      chk("latency", 16'(n), 16'(WS + 1));
      if (seen) begin
         rdy_gap      = cyc - last_rdy_cyc;
         last_rdy_cyc = cyc;
      end
      @(posedge clk); #1;
      if (!hold) req = 1'b0;
   endtask

   // Monitor: pops one expectation per rdy pulse; io_out is checked the cycle after
   initial begin
      exp_t       e;
      bit         io_pend;
      logic [7:0] io_exp;
      io_pend = 1'b0;
      io_exp  = 8'h00;
      forever begin
         @(negedge clk);
         if (io_pend) begin
            chk("io_out", 16'(io_out), 16'(io_exp));
            io_pend = 1'b0;
         end
         if (rdy) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_rdy actual=1 required=0");
            end else begin
               e = sb_q.pop_front();
               chk(e.rd ? "rdata_read" : "rdata_hold", 16'(rdata), 16'(e.rdata));
               chk("bus_err", 16'(bus_err), 16'(e.berr));
               chk("io_stb", 16'(io_stb), 16'(e.stb));
               io_exp  = e.io_out;
               io_pend = 1'b1;
            end
         end else if (io_stb || bus_err) begin
            chk("stray_pulse", 16'({io_stb, bus_err}), 16'h0000);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] a;
      int          sel;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_rdy", 16'(rdy), 16'h0);
      chk("rst_bus_err", 16'(bus_err), 16'h0);
      chk("rst_io_stb", 16'(io_stb), 16'h0);
      chk("rst_rdata", 16'(rdata), 16'h00);
      chk("rst_io_out", 16'(io_out), 16'h00);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // RAM write/read
      issue(16'h0010, 1'b0, 8'h5A, 8'h00, 0, 1'b0);
      issue(16'h0010, 1'b1, 8'h00, 8'h00, 0, 1'b0);

      // Vector bytes, and a dropped vector write
      issue(16'hFFFC, 1'b1, 8'h00, 8'h00, 0, 1'b0);
      issue(16'hFFFD, 1'b1, 8'h00, 8'h00, 0, 1'b0);
      issue(16'hFFFC, 1'b0, 8'hFF, 8'h00, 0, 1'b0);
      issue(16'hFFFC, 1'b1, 8'h00, 8'h00, 0, 1'b0);

      // I/O port
      issue(16'hF000, 1'b0, 8'h41, 8'h00, 0, 1'b0);
      issue(16'hF000, 1'b1, 8'h00, 8'h99, 0, 1'b0);

      // Unmapped read and write
      issue(16'h9000, 1'b1, 8'h00, 8'h00, 0, 1'b0);
      issue(16'h9000, 1'b0, 8'h12, 8'h00, 0, 1'b0);

      // RAM top byte and first byte above RAM must not alias
      issue(16'h07FF, 1'b0, 8'hC3, 8'h00, 0, 1'b0);
      issue(16'h0810, 1'b0, 8'h33, 8'h00, 0, 1'b0);
      issue(16'h0010, 1'b1, 8'h00, 8'h00, 0, 1'b0);
      issue(16'h07FF, 1'b1, 8'h00, 8'h00, 0, 1'b0);

      // req held high across three reads
      issue(16'h0010, 1'b1, 8'h00, 8'h00, 0, 1'b1);
      issue(16'h07FF, 1'b1, 8'h00, 8'h00, 0, 1'b1);
      chk("rdy_gap_1", 16'(rdy_gap), 16'(WS + 2));
      issue(16'hFFFD, 1'b1, 8'h00, 8'h00, 0, 1'b0);
      chk("rdy_gap_2", 16'(rdy_gap), 16'(WS + 2));

      // Inputs changing and req dropping after acceptance
      issue(16'h0010, 1'b1, 8'h00, 8'h00, 1, 1'b0);
      issue(16'h07FF, 1'b0, 8'h3C, 8'h00, 1, 1'b0);
      issue(16'h07FF, 1'b1, 8'h00, 8'h00, 2, 1'b0);

      // Reset during WAIT abandons the write
      issue(16'h0020, 1'b0, 8'h11, 8'h00, 0, 1'b0);
      io_in  = 8'h00;
      addr   = 16'h0020;
      mem_rw = 1'b0;
      wdata  = 8'h77;
      req    = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("rstw_rdy", 16'(rdy), 16'h0);
      chk("rstw_bus_err", 16'(bus_err), 16'h0);
      chk("rstw_io_stb", 16'(io_stb), 16'h0);
      chk("rstw_rdata", 16'(rdata), 16'h00);
      chk("rstw_io_out", 16'(io_out), 16'h00);
      req    = 1'b0;
      rst_n  = 1'b1;
      m_io   = 8'h00;
      m_last = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      chk("rstw_no_rdy", 16'(sb_q.size()), 16'h0);
      issue(16'h0020, 1'b1, 8'h00, 8'h00, 0, 1'b0);

      // Fill low RAM so random reads always hit known data
      for (int i = 0; i < 64; i++)
         issue(16'(i), 1'b0, 8'($urandom), 8'h00, 0, 1'b0);

      for (int k = 0; k < 80; k++) begin
         sel = $urandom_range(0, 9);
         case (sel)
            0, 1, 2, 3: a = 16'($urandom_range(0, 63));
            4:          a = 16'h07FF;
            5:          a = 16'hF000;
            6:          a = ($urandom_range(0, 1) == 0) ? 16'hFFFC : 16'hFFFD;
            7:          a = 16'($urandom_range(32'h0800, 32'hEFFF));
            8:          a = ($urandom_range(0, 1) == 0) ? 16'hFFFE : 16'hF001;
            default:    a = 16'h0800;
         endcase
         issue(a, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0,
               1'($urandom_range(0, 1)));
      end

      req = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("sb_empty", 16'(sb_q.size()), 16'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
